// File: rtl/i2c_fifo_master.sv
// Byte-oriented I2C master: 4-deep TX/RX FIFOs, strobe-launched START/addr/data/STOP transactions.
// Optional macro I2C_NACK_ABORT_EN: a slave NACK in an address/write ACK slot goes straight to STOP.
module i2c_fifo_master #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned QDIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic       rd,
    input  logic       rd_wr_en,
    input  logic       start,
    output logic       empty_tx,
    output logic       full_tx,
    output logic       empty_rx,
    output logic       full_rx,
    input  logic [6:0] w_addr,
    input  logic [7:0] w_fifo_data,
    output logic [7:0] r_fifo_data,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam int unsigned QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [QW-1:0] QLAST   = QW'(QDIV - 1);
`ifdef I2C_NACK_ABORT_EN
    localparam bit NACK_ABORT = 1'b1;
`else
    localparam bit NACK_ABORT = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [QW-1:0]     qcnt_q, qcnt_d;
    logic [1:0]        quarter_q, quarter_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic [CW-1:0]     rx_left_q, rx_left_d;
    logic              scl_d, sda_oe, sda_oe_d;
    logic              qend_c, bit_end_c;
    logic              tx_pop_c, rx_push_c;

    logic [7:0]        tx_mem [DEPTH];
    logic [ADDR_W-1:0] tx_wptr, tx_rptr;
    logic [CW-1:0]     tx_count, tx_count_d;
    logic              tx_push_c;
    logic [7:0]        rx_mem [DEPTH];
    logic [ADDR_W-1:0] rx_wptr, rx_rptr;
    logic [CW-1:0]     rx_count, rx_count_d;
    logic              rx_pop_c, rx_push_ok_c;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Bit engine state register; bus pins are registered from the next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            rx_left_q <= '0;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            rx_left_q <= rx_left_d;
            scl       <= scl_d;
            sda_oe    <= sda_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        rx_left_d = rx_left_q;
        tx_pop_c  = 1'b0;
        rx_push_c = 1'b0;
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;
        qend_c    = (qcnt_q == QLAST);
        bit_end_c = qend_c && (quarter_q == 2'd3);

        if (state_q != S_IDLE) begin
            qcnt_d = qend_c ? '0 : qcnt_q + QW'(1);
            if (qend_c) quarter_d = quarter_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_START;
                    qcnt_d    = '0;
                    quarter_d = '0;
                    bit_d     = '0;
                    shift_d   = {w_addr, rd_wr_en};
                    rw_d      = rd_wr_en;
                    // Read length is the RX free space right now, at least one byte
                    rx_left_d = (rx_count == DEPTH_C) ? CW'(1) : DEPTH_C - rx_count;
                end
            end
            S_START: if (bit_end_c) state_d = S_ADDR;
            S_ADDR, S_WDATA: begin
                if (bit_end_c) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                end
            end
            S_AACK, S_WACK: begin
                if (qend_c && quarter_q == 2'd2) ack_d = sda;
                if (bit_end_c) begin
                    if (NACK_ABORT && ack_q) begin
                        state_d = S_STOP;
                    end else if (state_q == S_AACK && rw_q) begin
                        state_d = S_RDATA;
                    end else if (tx_count != '0) begin
                        state_d  = S_WDATA;
                        tx_pop_c = 1'b1;
                        shift_d  = tx_mem[tx_rptr];
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_RDATA: begin
                if (qend_c && quarter_q == 2'd2) shift_d = {shift_q[6:0], sda};
                if (bit_end_c) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rx_push_c = 1'b1;
                        rx_left_d = rx_left_q - CW'(1);
                        state_d   = S_RACK;
                    end
                end
            end
            S_RACK: if (bit_end_c) state_d = (rx_left_q == '0) ? S_STOP : S_RDATA;
            S_STOP: if (bit_end_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pin levels for the upcoming cycle
        unique case (state_d)
            S_START: sda_oe_d = quarter_d[1];
            S_ADDR, S_WDATA: begin
                scl_d    = quarter_d[1];
                sda_oe_d = ~shift_d[7];
            end
            S_AACK, S_WACK, S_RDATA: scl_d = quarter_d[1];
            S_RACK: begin
                scl_d    = quarter_d[1];
                sda_oe_d = (rx_left_d != '0);
            end
            S_STOP: begin
                scl_d    = (quarter_d != 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    assign tx_push_c  = wr && (tx_count != DEPTH_C);
    assign tx_count_d = tx_count + CW'(tx_push_c) - CW'(tx_pop_c);

    // TX FIFO: host pushes, FSM pops
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            empty_tx <= 1'b1;
            full_tx  <= 1'b0;
        end else begin
            if (tx_push_c) begin
                tx_mem[tx_wptr] <= w_fifo_data;
                tx_wptr         <= tx_wptr + ADDR_W'(1);
            end
            if (tx_pop_c) tx_rptr <= tx_rptr + ADDR_W'(1);
            tx_count <= tx_count_d;
            empty_tx <= (tx_count_d == '0);
            full_tx  <= (tx_count_d == DEPTH_C);
        end
    end

    assign rx_pop_c     = rd && (rx_count != '0);
    assign rx_push_ok_c = rx_push_c && ((rx_count != DEPTH_C) || rx_pop_c);
    assign rx_count_d   = rx_count + CW'(rx_push_ok_c) - CW'(rx_pop_c);

    // RX FIFO: FSM pushes (a byte with no room is dropped), host pops into r_fifo_data
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_count    <= '0;
            empty_rx    <= 1'b1;
            full_rx     <= 1'b0;
            r_fifo_data <= '0;
        end else begin
            if (rx_push_ok_c) begin
                rx_mem[rx_wptr] <= shift_q;
                rx_wptr         <= rx_wptr + ADDR_W'(1);
            end
            if (rx_pop_c) begin
                r_fifo_data <= rx_mem[rx_rptr];
                rx_rptr     <= rx_rptr + ADDR_W'(1);
            end
            rx_count <= rx_count_d;
            empty_rx <= (rx_count_d == '0);
            full_rx  <= (rx_count_d == DEPTH_C);
        end
    end

endmodule

// File: tb/tb_i2c_fifo_master.sv
// Self-checking bench for i2c_fifo_master: bus-level monitor plus slave model, queue-based FIFO model.
module tb_i2c_fifo_master;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned QDIV   = 2;
    localparam int DEPTH   = 4;
    localparam int BIT_CYC = 4 * QDIV;

    logic       clk = 1'b0, reset = 1'b1, wr = 1'b0, rd = 1'b0, rd_wr_en = 1'b0, start = 1'b0;
    logic [6:0] w_addr = '0;
    logic [7:0] w_fifo_data = '0;
    wire        empty_tx, full_tx, empty_rx, full_rx, scl;
    wire  [7:0] r_fifo_data;
    wire        sda;
    logic       slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_fifo_master #(.ADDR_W(ADDR_W), .QDIV(QDIV)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .rd_wr_en(rd_wr_en), .start(start),
        .empty_tx(empty_tx), .full_tx(full_tx), .empty_rx(empty_rx), .full_rx(full_rx),
        .w_addr(w_addr), .w_fifo_data(w_fifo_data), .r_fifo_data(r_fifo_data),
        .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    // Bus observer and slave state
    int         start_cnt = 0, stop_cnt = 0, start_cyc = 0, stop_cyc = 0;
    int         bitpos = 0, frame = 0;
    bit         in_txn = 0, rd_mode = 0, nacked = 0, slave_present = 1;
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0] shreg = '0;
    logic [7:0] obs_bytes[$];
    logic       obs_ack[$];
    logic [7:0] rd_src [8];
    logic [7:0] rxq[$];

    // Decode START/STOP/9-bit frames; slave ACKs address/write bytes and serves read data
    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda;
        if (reset) begin
            in_txn    = 0;
            slave_low = 1'b0;
        end else if (s_scl && p_scl && p_sda && !s_sda) begin
            start_cnt++; start_cyc = cyc;
            in_txn = 1; bitpos = 0; frame = 0; rd_mode = 0; nacked = 0; shreg = '0;
        end else if (s_scl && p_scl && !p_sda && s_sda) begin
            stop_cnt++; stop_cyc = cyc;
            in_txn = 0; slave_low = 1'b0;
        end else if (in_txn && s_scl && !p_scl) begin
            if (bitpos < 8) begin
                shreg = {shreg[6:0], s_sda};
                bitpos++;
            end else begin
                obs_bytes.push_back(shreg);
                obs_ack.push_back(s_sda);
                if (frame == 0) rd_mode = shreg[0];
                else if (rd_mode && s_sda) nacked = 1;
                frame++;
                bitpos = 0;
            end
        end else if (in_txn && !s_scl && p_scl) begin
            slave_low = 1'b0;
            if (bitpos == 8)
                slave_low = slave_present && (frame == 0 || !rd_mode);
            else if (rd_mode && frame > 0 && frame <= 8 && !nacked)
                slave_low = !rd_src[frame-1][7-bitpos];
        end
        p_scl = s_scl;
        p_sda = s_sda;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk); wr = 1'b1; w_fifo_data = d;
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic pop_rx(output logic [7:0] d);
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        d = r_fifo_data;
    endtask

    task automatic pulse_start(input logic [6:0] a, input logic rw, output int t0);
        @(negedge clk); start = 1'b1; w_addr = a; rd_wr_en = rw;
        @(posedge clk); #1; t0 = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_stop(input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (stop_cnt >= target) begin ok = 1; break; end
        end
        if (ok) tick(BIT_CYC);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty_tx !== 1'b1) begin errors++; $display("FAIL reset_empty_tx: got %b expected 1", empty_tx); end
        checks++; if (full_tx !== 1'b0) begin errors++; $display("FAIL reset_full_tx: got %b expected 0", full_tx); end
        checks++; if (empty_rx !== 1'b1) begin errors++; $display("FAIL reset_empty_rx: got %b expected 1", empty_rx); end
        checks++; if (full_rx !== 1'b0) begin errors++; $display("FAIL reset_full_rx: got %b expected 0", full_rx); end
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda_released: got %b expected 1", sda); end
        checks++; if (r_fifo_data !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", r_fifo_data); end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] vals [4];
        vals = '{8'hAA, 8'hBB, 8'h56, 8'h37};
        for (int i = 0; i < 4; i++) begin
            push_tx(vals[i]);
            checks++;
            if (full_tx !== (i == 3)) begin errors++; $display("FAIL fill_full_tx[%0d]: got %b expected %b", i, full_tx, (i == 3)); end
            checks++;
            if (empty_tx !== 1'b0) begin errors++; $display("FAIL fill_empty_tx[%0d]: got %b expected 0", i, empty_tx); end
        end
        push_tx(8'h99);
        checks++; if (full_tx !== 1'b1) begin errors++; $display("FAIL fill_overflow_full: got %b expected 1", full_tx); end
    endtask

    task automatic test_write_burst();
        logic [7:0] exp [5];
        int base, s0, p0, t0, t1;
        bit ok;
        exp = '{8'h2A, 8'hAA, 8'hBB, 8'h56, 8'h37};
        slave_present = 1;
        base = obs_bytes.size(); s0 = start_cnt; p0 = stop_cnt;
        pulse_start(7'h15, 1'b0, t0);
        while (cyc < t0 + 291) @(negedge clk);
        pulse_start(7'h15, 1'b0, t1);
        wait_stop(p0 + 1, 600, ok);
        tick(40);
        checks++; if (!ok) begin errors++; $display("FAIL wb_stop_timeout: got no STOP expected STOP"); end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL wb_busy_start: got %0d STARTs expected 1", start_cnt - s0); end
        checks++; if (obs_bytes.size() - base != 5) begin errors++; $display("FAIL wb_frames: got %0d expected 5", obs_bytes.size() - base); end
        for (int i = 0; i < 5; i++) begin
            if (base + i < obs_bytes.size()) begin
                checks++;
                if (obs_bytes[base+i] !== exp[i]) begin errors++; $display("FAIL wb_byte[%0d]: got %h expected %h", i, obs_bytes[base+i], exp[i]); end
                checks++;
                if (obs_ack[base+i] !== 1'b0) begin errors++; $display("FAIL wb_ack[%0d]: got %b expected 0", i, obs_ack[base+i]); end
            end
        end
        checks++; if (start_cyc - t0 != 2 * QDIV) begin errors++; $display("FAIL wb_start_latency: got %0d expected %0d", start_cyc - t0, 2 * QDIV); end
        checks++;
        if (stop_cyc - t0 != BIT_CYC * (11 + 9 * 4) - 2 * QDIV) begin
            errors++; $display("FAIL wb_duration: got %0d expected %0d", stop_cyc - t0 + 2 * QDIV, BIT_CYC * (11 + 9 * 4));
        end
        checks++; if (empty_tx !== 1'b1) begin errors++; $display("FAIL wb_empty_tx: got %b expected 1", empty_tx); end
    endtask

    task automatic test_random_writes();
        for (int it = 0; it < 4; it++) begin
            int n, base, p0, t0;
            bit ok;
            logic [6:0] a;
            logic [7:0] exp[$];
            n = (it == 0) ? 0 : int'($urandom_range(1, DEPTH));
            a = 7'($urandom);
            exp.delete();
            exp.push_back({a, 1'b0});
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                d = 8'($urandom);
                exp.push_back(d);
                push_tx(d);
            end
            checks++; if (full_tx !== (n == DEPTH)) begin errors++; $display("FAIL rw_full_tx[%0d]: got %b expected %b", it, full_tx, (n == DEPTH)); end
            base = obs_bytes.size(); p0 = stop_cnt;
            pulse_start(a, 1'b0, t0);
            wait_stop(p0 + 1, BIT_CYC * (12 + 9 * n), ok);
            checks++; if (!ok) begin errors++; $display("FAIL rw_stop_timeout[%0d]: got no STOP expected STOP", it); end
            checks++;
            if (obs_bytes.size() - base != n + 1) begin errors++; $display("FAIL rw_frames[%0d]: got %0d expected %0d", it, obs_bytes.size() - base, n + 1); end
            for (int i = 0; i <= n; i++) begin
                if (base + i < obs_bytes.size()) begin
                    checks++;
                    if (obs_bytes[base+i] !== exp[i]) begin errors++; $display("FAIL rw_byte[%0d][%0d]: got %h expected %h", it, i, obs_bytes[base+i], exp[i]); end
                end
            end
            checks++;
            if (stop_cyc - t0 != BIT_CYC * (11 + 9 * n) - 2 * QDIV) begin
                errors++; $display("FAIL rw_duration[%0d]: got %0d expected %0d", it, stop_cyc - t0 + 2 * QDIV, BIT_CYC * (11 + 9 * n));
            end
            checks++; if (empty_tx !== 1'b1) begin errors++; $display("FAIL rw_empty_tx[%0d]: got %b expected 1", it, empty_tx); end
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [4];
        logic [7:0] d;
        int base, p0, t0;
        bit ok;
        exp = '{8'h5A, 8'hC3, 8'h11, 8'h7E};
        for (int i = 0; i < 4; i++) rd_src[i] = exp[i];
        slave_present = 1;
        base = obs_bytes.size(); p0 = stop_cnt;
        pulse_start(7'h15, 1'b1, t0);
        wait_stop(p0 + 1, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_stop_timeout: got no STOP expected STOP"); end
        checks++; if (obs_bytes.size() - base != 5) begin errors++; $display("FAIL rd_frames: got %0d expected 5", obs_bytes.size() - base); end
        if (base < obs_bytes.size()) begin
            checks++; if (obs_bytes[base] !== 8'h2B) begin errors++; $display("FAIL rd_addr_byte: got %h expected 2b", obs_bytes[base]); end
        end
        for (int i = 0; i < 4; i++) begin
            if (base + 1 + i < obs_bytes.size()) begin
                checks++;
                if (obs_ack[base+1+i] !== (i == 3)) begin errors++; $display("FAIL rd_master_ack[%0d]: got %b expected %b", i, obs_ack[base+1+i], (i == 3)); end
            end
        end
        checks++;
        if (stop_cyc - t0 != BIT_CYC * (11 + 9 * 4) - 2 * QDIV) begin
            errors++; $display("FAIL rd_duration: got %0d expected %0d", stop_cyc - t0 + 2 * QDIV, BIT_CYC * (11 + 9 * 4));
        end
        checks++; if (full_rx !== 1'b1) begin errors++; $display("FAIL rd_full_rx: got %b expected 1", full_rx); end
        for (int i = 0; i < 4; i++) begin
            pop_rx(d);
            checks++; if (d !== exp[i]) begin errors++; $display("FAIL rd_pop[%0d]: got %h expected %h", i, d, exp[i]); end
        end
        checks++; if (empty_rx !== 1'b1) begin errors++; $display("FAIL rd_empty_rx: got %b expected 1", empty_rx); end
        pop_rx(d);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL rd_pop_empty_hold: got %h expected 7e", d); end
    endtask

    task automatic test_random_read();
        for (int it = 0; it < 4; it++) begin
            int k, m, base, p0, t0;
            bit ok;
            logic [6:0] a;
            logic [7:0] d, e;
            k = (it == 1) ? 0 : int'($urandom_range(0, rxq.size()));
            for (int i = 0; i < k; i++) begin
                pop_rx(d);
                e = rxq.pop_front();
                checks++; if (d !== e) begin errors++; $display("FAIL rr_pop[%0d][%0d]: got %h expected %h", it, i, d, e); end
            end
            for (int i = 0; i < 8; i++) rd_src[i] = 8'($urandom);
            m = (rxq.size() == DEPTH) ? 1 : DEPTH - rxq.size();
            for (int i = 0; i < m; i++) if (rxq.size() < DEPTH) rxq.push_back(rd_src[i]);
            a = 7'($urandom);
            base = obs_bytes.size(); p0 = stop_cnt;
            pulse_start(a, 1'b1, t0);
            wait_stop(p0 + 1, BIT_CYC * (12 + 9 * m), ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_stop_timeout[%0d]: got no STOP expected STOP", it); end
            checks++;
            if (obs_bytes.size() - base != m + 1) begin errors++; $display("FAIL rr_frames[%0d]: got %0d expected %0d", it, obs_bytes.size() - base, m + 1); end
            for (int i = 0; i < m; i++) begin
                if (base + 1 + i < obs_bytes.size()) begin
                    checks++;
                    if (obs_ack[base+1+i] !== (i == m - 1)) begin errors++; $display("FAIL rr_master_ack[%0d][%0d]: got %b expected %b", it, i, obs_ack[base+1+i], (i == m - 1)); end
                end
            end
            checks++; if (full_rx !== (rxq.size() == DEPTH)) begin errors++; $display("FAIL rr_full_rx[%0d]: got %b expected %b", it, full_rx, (rxq.size() == DEPTH)); end
            checks++; if (empty_rx !== (rxq.size() == 0)) begin errors++; $display("FAIL rr_empty_rx[%0d]: got %b expected %b", it, empty_rx, (rxq.size() == 0)); end
        end
    endtask

    task automatic test_reset_mid();
        int s0, t0;
        checks++; if (empty_rx !== (rxq.size() == 0)) begin errors++; $display("FAIL rm_pre_empty_rx: got %b expected %b", empty_rx, (rxq.size() == 0)); end
        push_tx(8'h3C);
        push_tx(8'hC5);
        slave_present = 1;
        pulse_start(7'h2D, 1'b0, t0);
        tick(100);
        @(negedge clk); reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rxq.delete();
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL rm_scl: got %b expected 1", scl); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda: got %b expected 1", sda); end
        checks++; if (empty_tx !== 1'b1) begin errors++; $display("FAIL rm_empty_tx: got %b expected 1", empty_tx); end
        checks++; if (empty_rx !== 1'b1) begin errors++; $display("FAIL rm_empty_rx: got %b expected 1", empty_rx); end
        checks++; if (r_fifo_data !== 8'h00) begin errors++; $display("FAIL rm_rdata: got %h expected 00", r_fifo_data); end
        s0 = start_cnt;
        tick(200);
        checks++; if (start_cnt != s0) begin errors++; $display("FAIL rm_no_restart: got %0d STARTs expected 0", start_cnt - s0); end
    endtask

    task automatic test_nack();
        logic [7:0] exp[$];
        logic [6:0] a;
        int base, p0, t0;
        bit ok;
        a = 7'($urandom);
        exp.push_back({a, 1'b0});
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            exp.push_back(d);
            push_tx(d);
        end
        slave_present = 0;
        base = obs_bytes.size(); p0 = stop_cnt;
        pulse_start(a, 1'b0, t0);
        wait_stop(p0 + 1, BIT_CYC * 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nk_stop_timeout: got no STOP expected STOP"); end
        if (base < obs_bytes.size()) begin
            checks++; if (obs_ack[base] !== 1'b1) begin errors++; $display("FAIL nk_addr_nack: got %b expected 1", obs_ack[base]); end
        end
`ifdef I2C_NACK_ABORT_EN
        checks++; if (obs_bytes.size() - base != 1) begin errors++; $display("FAIL nk_frames: got %0d expected 1", obs_bytes.size() - base); end
        checks++;
        if (stop_cyc - t0 != BIT_CYC * 11 - 2 * QDIV) begin
            errors++; $display("FAIL nk_duration: got %0d expected %0d", stop_cyc - t0 + 2 * QDIV, BIT_CYC * 11);
        end
        checks++; if (full_tx !== 1'b1) begin errors++; $display("FAIL nk_tx_kept: got %b expected 1", full_tx); end
        do_reset();
`else
        checks++; if (obs_bytes.size() - base != DEPTH + 1) begin errors++; $display("FAIL nk_frames: got %0d expected %0d", obs_bytes.size() - base, DEPTH + 1); end
        for (int i = 0; i <= DEPTH; i++) begin
            if (base + i < obs_bytes.size()) begin
                checks++;
                if (obs_bytes[base+i] !== exp[i]) begin errors++; $display("FAIL nk_byte[%0d]: got %h expected %h", i, obs_bytes[base+i], exp[i]); end
            end
        end
        checks++;
        if (stop_cyc - t0 != BIT_CYC * (11 + 9 * DEPTH) - 2 * QDIV) begin
            errors++; $display("FAIL nk_duration: got %0d expected %0d", stop_cyc - t0 + 2 * QDIV, BIT_CYC * (11 + 9 * DEPTH));
        end
        checks++; if (empty_tx !== 1'b1) begin errors++; $display("FAIL nk_empty_tx: got %b expected 1", empty_tx); end
`endif
        slave_present = 1;
    endtask

    initial begin
        test_reset();
        test_fifo_fill();
        test_write_burst();
        test_random_writes();
        test_read();
        test_random_read();
        test_reset_mid();
        test_nack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
